// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Shares one lane-wise shifter between two requesters (port 0: main
//   execute, port 1: aux/vector issue). Round-robin arbitration with
//   valid/ready handshakes; results, source port and tag are queued in an
//   in-order FIFO that feeds a single back-pressurable response port.
//   Optional feature: define SHIFT_ARB_PERF_EN to add the perf_grant0,
//   perf_grant1 and perf_conflict counters (wrap modulo 2^32).
module shift_arbiter #(
   parameter int TAG_W = 4,
   parameter int DEPTH = 2          // power of 2, >= 2
) (
   input  logic             clk,
   input  logic             reset_n,
`ifdef SHIFT_ARB_PERF_EN
   output logic [31:0]      perf_grant0,
   output logic [31:0]      perf_grant1,
   output logic [31:0]      perf_conflict,
`endif
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [0:63]      req0_op1,
   input  logic [0:63]      req0_op2,
   input  logic [1:0]       req0_ww,
   input  logic [1:0]       req0_la_lr,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [0:63]      req1_op1,
   input  logic [0:63]      req1_op2,
   input  logic [1:0]       req1_ww,
   input  logic [1:0]       req1_la_lr,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [0:63]      rsp_data,
   output logic             rsp_src,
   output logic [TAG_W-1:0] rsp_tag
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [63:0]      data;
      logic             src;
      logic [TAG_W-1:0] tag;
   } entry_t;

   // Lane-wise shift. Operands are handled as plain numeric 64-bit values;
   // each lane's amount is the low log2(lane width) bits of its op2 lane.
   // la_lr: bit0 -> left logical (wins over bit1), bit1 -> right logical,
   // 00 -> right arithmetic.
   function automatic logic [63:0] shift_lanes(input logic [63:0] a,
                                                input logic [63:0] b,
                                                input logic [1:0]  ww,
                                                input logic [1:0]  la_lr);
      logic [63:0] r;
      logic [7:0]  x8;
      logic [15:0] x16;
      logic [31:0] x32;
      r = '0;
      case (ww)
         2'b00: for (int i = 0; i < 8; i++) begin
            x8 = a[i*8 +: 8];
            if (la_lr[0])      r[i*8 +: 8] = x8 << b[i*8 +: 3];
            else if (la_lr[1]) r[i*8 +: 8] = x8 >> b[i*8 +: 3];
            else               r[i*8 +: 8] = $signed(x8) >>> b[i*8 +: 3];
         end
         2'b01: for (int i = 0; i < 4; i++) begin
            x16 = a[i*16 +: 16];
            if (la_lr[0])      r[i*16 +: 16] = x16 << b[i*16 +: 4];
            else if (la_lr[1]) r[i*16 +: 16] = x16 >> b[i*16 +: 4];
            else               r[i*16 +: 16] = $signed(x16) >>> b[i*16 +: 4];
         end
         2'b10: for (int i = 0; i < 2; i++) begin
            x32 = a[i*32 +: 32];
            if (la_lr[0])      r[i*32 +: 32] = x32 << b[i*32 +: 5];
            else if (la_lr[1]) r[i*32 +: 32] = x32 >> b[i*32 +: 5];
            else               r[i*32 +: 32] = $signed(x32) >>> b[i*32 +: 5];
         end
         default: begin
            if (la_lr[0])      r = a << b[5:0];
            else if (la_lr[1]) r = a >> b[5:0];
            else               r = $signed(a) >>> b[5:0];
         end
      endcase
      return r;
   endfunction

   logic             rr_q, rr_d;          // 1 -> port 1 wins a contention
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];

   logic             full, grant0, grant1, push, pop;
   logic [63:0]      sel_op1, sel_op2, shift_res;
   logic [1:0]       sel_ww, sel_la_lr;
   logic [TAG_W-1:0] sel_tag;
   entry_t           head;

   // Arbitration and handshakes; readies depend only on state and valids.
   always_comb begin
      full       = (count_q == CNT_W'(DEPTH));
      grant1     = req1_valid & (~req0_valid | rr_q);
      grant0     = req0_valid & ~grant1;
      req0_ready = grant0 & ~full;
      req1_ready = grant1 & ~full;
      push       = req0_ready | req1_ready;   // ready implies valid
      pop        = rsp_valid & rsp_ready;
   end

   // Mux the granted port into the single shifter.
   always_comb begin
      sel_op1   = grant1 ? req1_op1   : req0_op1;
      sel_op2   = grant1 ? req1_op2   : req0_op2;
      sel_ww    = grant1 ? req1_ww    : req0_ww;
      sel_la_lr = grant1 ? req1_la_lr : req0_la_lr;
      sel_tag   = grant1 ? req1_tag   : req0_tag;
      shift_res = shift_lanes(sel_op1, sel_op2, sel_ww, sel_la_lr);
   end

   // FIFO and round-robin next state.
   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      rr_d     = rr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{data: shift_res, src: grant1, tag: sel_tag};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         rr_d            = grant0;             // point at the other port
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers.
   // NOTE: sequential blocks use non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rr_q     <= rr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage.
   // NOTE: storage is deliberately not reset; count_q alone marks entries
   // valid, and the response outputs are forced to zero while empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Response port: head entry, zeroed when the FIFO is empty.
   always_comb begin
      head      = mem_q[rd_ptr_q];
      rsp_valid = (count_q != '0);
      rsp_data  = rsp_valid ? head.data : '0;
      rsp_src   = rsp_valid & head.src;
      rsp_tag   = rsp_valid ? head.tag : '0;
   end

`ifdef SHIFT_ARB_PERF_EN
   logic [31:0] perf_grant0_q, perf_grant0_d;
   logic [31:0] perf_grant1_q, perf_grant1_d;
   logic [31:0] perf_conflict_q, perf_conflict_d;

   // Performance counter increments; all wrap naturally.
   always_comb begin
      perf_grant0_d   = perf_grant0_q + {31'd0, req0_ready & req0_valid};
      perf_grant1_d   = perf_grant1_q + {31'd0, req1_ready & req1_valid};
      perf_conflict_d = perf_conflict_q + {31'd0, req0_valid & req1_valid & ~full};
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_grant0_q   <= '0;
         perf_grant1_q   <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_grant0_q   <= perf_grant0_d;
         perf_grant1_q   <= perf_grant1_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_grant0   = perf_grant0_q;
   assign perf_grant1   = perf_grant1_q;
   assign perf_conflict = perf_conflict_q;
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: directed cases plus randomized traffic,
// checked by a reference model feeding a scoreboard queue and a separate
// response monitor.
module tb_shift_arbiter;
   localparam int TAG_W = 4;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [0:63]      req0_op1, req0_op2, req1_op1, req1_op2;
   logic [1:0]       req0_ww, req0_la_lr, req1_ww, req1_la_lr;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic             rsp_valid, rsp_ready, rsp_src;
   logic [0:63]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;
`ifdef SHIFT_ARB_PERF_EN
   logic [31:0]      perf_grant0, perf_grant1, perf_conflict;
`endif

   always #5 clk = ~clk;

   shift_arbiter #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
`ifdef SHIFT_ARB_PERF_EN
      .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict),
`endif
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
      .req0_op2(req0_op2), .req0_ww(req0_ww), .req0_la_lr(req0_la_lr), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
      .req1_op2(req1_op2), .req1_ww(req1_ww), .req1_la_lr(req1_la_lr), .req1_tag(req1_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_src(rsp_src), .rsp_tag(rsp_tag)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference shifter: each lane extracted with plain arithmetic; the
   // arithmetic right shift fills the vacated top bits when the sign is set.
   function automatic logic [63:0] ref_shift(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] ww, input logic [1:0] la_lr);
      int          w, amt;
      logic [63:0] mask, x, y, r;
      w    = 8 << ww;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      r    = '0;
      for (int i = 0; i < 64 / w; i++) begin
         x   = (a >> (i * w)) & mask;
         amt = int'(((b >> (i * w)) & mask) % 64'(w));
         if (la_lr[0])      y = (x << amt) & mask;
         else if (la_lr[1]) y = x >> amt;
         else begin
            y = x >> amt;
            if (x[w-1]) y = y | (mask & ~(mask >> amt));
         end
         r = r | (y << (i * w));
      end
      return r;
   endfunction

   typedef struct {
      logic [63:0]      data;
      logic             src;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   m_count;
   bit   m_rr;                 // 1 -> port 1 is favoured on contention
   bit   m_full, m_take0, m_take1, m_pop;
   exp_t m_e;

   // Reference model: predicts readies/rsp_valid and pushes expected responses.
   always @(negedge clk) begin
      if (!reset_n) begin
         m_count = 0;
         m_rr    = 1'b0;
         exp_q.delete();
         check("reset_req0_ready", req0_ready, 0);
         check("reset_req1_ready", req1_ready, 0);
         check("reset_rsp_valid", rsp_valid, 0);
      end else begin
         m_full  = (m_count == DEPTH);
         m_take0 = 1'b0;
         m_take1 = 1'b0;
         if (!m_full) begin
            if (req0_valid && req1_valid) begin
               m_take0 = !m_rr;
               m_take1 = m_rr;
            end else begin
               m_take0 = req0_valid;
               m_take1 = req1_valid;
            end
         end
         check("req0_ready", req0_ready, m_take0);
         check("req1_ready", req1_ready, m_take1);
         check("rsp_valid", rsp_valid, m_count != 0);
         m_pop = rsp_ready && (m_count != 0);
         if (m_take0) begin
            m_e = '{data: ref_shift(req0_op1, req0_op2, req0_ww, req0_la_lr), src: 1'b0, tag: req0_tag};
            exp_q.push_back(m_e);
            m_rr = 1'b1;
         end
         if (m_take1) begin
            m_e = '{data: ref_shift(req1_op1, req1_op2, req1_ww, req1_la_lr), src: 1'b1, tag: req1_tag};
            exp_q.push_back(m_e);
            m_rr = 1'b0;
         end
         m_count = m_count + int'(m_take0 | m_take1) - int'(m_pop);
      end
   end

   // Monitor: compares the presented head with the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", rsp_valid, 0);
         end else begin
            check("rsp_data", rsp_data, exp_q[0].data);
            check("rsp_src", rsp_src, exp_q[0].src);
            check("rsp_tag", rsp_tag, exp_q[0].tag);
            if (rsp_ready) void'(exp_q.pop_front());
         end
      end
   end

   bit acc0, acc1;

   // One clock: capture handshakes mid-cycle, then return just after the edge.
   task automatic step();
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic new_req(input int p);
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (p == 0) begin
         req0_valid = 1'b1; req0_op1 = a; req0_op2 = b;
         req0_ww = 2'($urandom); req0_la_lr = 2'($urandom); req0_tag = TAG_W'($urandom);
      end else begin
         req1_valid = 1'b1; req1_op1 = a; req1_op2 = b;
         req1_ww = 2'($urandom); req1_la_lr = 2'($urandom); req1_tag = TAG_W'($urandom);
      end
   endtask

   task automatic drain();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 20 && rsp_valid; i++) step();
      check("drain_empty", rsp_valid, 0);
   endtask

   // Both ports valid every cycle; accepts must alternate starting at port 0.
   task automatic contention(input string name);
`ifdef SHIFT_ARB_PERF_EN
      logic [31:0] c0, g0, g1;
`endif
      rsp_ready = 1'b1;
      new_req(0);
      new_req(1);
`ifdef SHIFT_ARB_PERF_EN
      c0 = perf_conflict; g0 = perf_grant0; g1 = perf_grant1;
`endif
      for (int k = 0; k < 4; k++) begin
         step();
         check({name, "_acc0"}, acc0, (k % 2) == 0);
         check({name, "_acc1"}, acc1, (k % 2) == 1);
         if (acc0) new_req(0);
         if (acc1) new_req(1);
      end
`ifdef SHIFT_ARB_PERF_EN
      check({name, "_perf_conflict"}, perf_conflict - c0, 4);
      check({name, "_perf_grant0"}, perf_grant0 - g0, 2);
      check({name, "_perf_grant1"}, perf_grant1 - g1, 2);
`endif
      drain();
   endtask

   int bp_tag;

   initial begin
      reset_n = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_ww = '0; req0_la_lr = '0; req0_tag = '0;
      req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_ww = '0; req1_la_lr = '0; req1_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_src", rsp_src, 0);
      check("rst_rsp_tag", rsp_tag, 0);
      reset_n = 1'b1;
      step();
      step();
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_req0_ready", req0_ready, 0);
      check("idle_req1_ready", req1_ready, 0);

      // Single 64-bit left shift on port 0.
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op1 = 64'h0102030405060708; req0_op2 = 64'd8;
      req0_ww = 2'b11; req0_la_lr = 2'b01; req0_tag = 4'hA;
      step();
      req0_valid = 1'b0;
      check("t1_accept", acc0, 1);
      check("t1_rsp_valid", rsp_valid, 1);
      check("t1_rsp_data", rsp_data, 64'h0203040506070800);
      check("t1_rsp_src", rsp_src, 0);
      check("t1_rsp_tag", rsp_tag, 4'hA);
      step();

      // Byte-lane logical right shift on port 1.
      req1_valid = 1'b1; req1_op1 = 64'h8080808080808080; req1_op2 = 64'h0303030303030303;
      req1_ww = 2'b00; req1_la_lr = 2'b10; req1_tag = 4'h5;
      step();
      req1_valid = 1'b0;
      check("t2_accept", acc1, 1);
      check("t2_rsp_valid", rsp_valid, 1);
      check("t2_rsp_data", rsp_data, 64'h1010101010101010);
      check("t2_rsp_src", rsp_src, 1);
      check("t2_rsp_tag", rsp_tag, 4'h5);
      step();

      contention("cont");

      // Backpressure: FIFO fills after two accepts, then everything drains in order.
      rsp_ready = 1'b0;
      bp_tag = 1;
      new_req(0); req0_tag = TAG_W'(bp_tag);
      for (int c = 0; c < 4; c++) begin
         step();
         if (acc0) begin
            bp_tag++;
            new_req(0); req0_tag = TAG_W'(bp_tag);
         end
      end
      check("bp_accepted_before_full", bp_tag, 3);
      check("bp_req0_ready_low", req0_ready, 0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 20 && bp_tag <= 4; c++) begin
         step();
         if (acc0) begin
            bp_tag++;
            if (bp_tag <= 4) begin
               new_req(0); req0_tag = TAG_W'(bp_tag);
            end else begin
               req0_valid = 1'b0;
            end
         end
      end
      check("bp_all_accepted", bp_tag, 5);
      drain();
      check("bp_none_lost", exp_q.size(), 0);

      // Reset with two entries queued.
      rsp_ready = 1'b0;
      new_req(0);
      step();
      new_req(0);
      step();
      req0_valid = 1'b0;
      check("mf_two_accepts", acc0, 1);
      check("mf_rsp_valid_before", rsp_valid, 1);
      reset_n = 1'b0;
      #1;
      check("mf_rsp_valid_drop", rsp_valid, 0);
      check("mf_rsp_data_zero", rsp_data, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
      check("mf_empty_after", rsp_valid, 0);
      contention("mf_cont");

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         rsp_ready = ($urandom_range(0, 99) < 65);
         if (!req0_valid && $urandom_range(0, 99) < 55) new_req(0);
         if (!req1_valid && $urandom_range(0, 99) < 55) new_req(1);
         step();
         if (acc0) req0_valid = 1'b0;
         if (acc1) req1_valid = 1'b0;
      end
      drain();
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1);
   end

endmodule
